// File: rtl/debounce_scheduler.sv
// debounce_scheduler: multi-channel input debouncer. NUM_CH two-flop
// synchronized inputs share one delay counter under round-robin scheduling.
// A channel whose synchronized level disagrees with its debounced level asks
// for the counter; once granted, it commits the new level after DELAY_TIME
// stable cycles, or gives the counter back as soon as the input bounces.
module debounce_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_WIDTH      = 2,
  parameter int DELAY_TIME    = 100,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_CH-1:0]   noisy_in,
  output logic [NUM_CH-1:0]   debounced_out,
  output logic [NUM_CH-1:0]   rise_pulse,
  output logic [NUM_CH-1:0]   fall_pulse,
  output logic                busy,
  output logic [CH_WIDTH-1:0] active_ch
);

  typedef enum logic {
    IDLE   = 1'b0,
    TIMING = 1'b1
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DELAY_TIME - 1);

  state_t                   state;
  logic [NUM_CH-1:0]        sync1;
  logic [NUM_CH-1:0]        s;
  logic [NUM_CH-1:0]        pending;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [CH_WIDTH-1:0]      ptr;
  logic [CH_WIDTH-1:0]      next_ptr;
  logic [CH_WIDTH-1:0]      grant;
  logic                     grant_valid;
  logic                     cur_level;
  logic                     cur_debounced;

  // Two-stage synchronizer bringing the asynchronous pads into the CLK domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= noisy_in;
      s     <= sync1;
    end
  end

  // A channel needs service whenever its settled input disagrees with the
  // level it last committed.
  assign pending = s ^ debounced_out;

  assign cur_level     = s[active_ch];
  assign cur_debounced = debounced_out[active_ch];

  // Pointer to the channel after the one just served, wrapping at NUM_CH-1.
  assign next_ptr = (int'(active_ch) == NUM_CH - 1) ? '0 : active_ch + 1'b1;

  // Round-robin search: first pending channel at or above ptr, wrapping.
  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!grant_valid && pending[idx]) begin
        grant       = CH_WIDTH'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  // Scheduler FSM: grants the counter, times the stable window, and commits
  // or aborts; pulses and busy are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      counter       <= '0;
      ptr           <= '0;
      active_ch     <= '0;
      debounced_out <= '0;
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      busy          <= 1'b0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            active_ch <= grant;
            counter   <= '0;
            busy      <= 1'b1;
            state     <= TIMING;
          end
        end
        TIMING: begin
          if (cur_level == cur_debounced) begin
            // Input bounced back to the committed level: release the counter.
            counter <= '0;
            ptr     <= next_ptr;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (counter == LAST_COUNT) begin
            debounced_out[active_ch] <= cur_level;
            if (cur_level) begin
              rise_pulse[active_ch] <= 1'b1;
            end else begin
              fall_pulse[active_ch] <= 1'b1;
            end
            counter <= '0;
            ptr     <= next_ptr;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
